xtensa_reset_seq: RTL
=====================

XTENSA_RESET_SEQ -- requirements
Module: xtensa_reset_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100: CLK cycles CoreBReset stays high after synchronized reset release; a value of 0 SHALL act as 1.
REQ-002 SHALL have parameter STALL_CYCLES, default 16: CLK cycles RunStall stays high after CoreBReset falls (used only with the macro).
REQ-003 SHALL have parameter CNT_W, default 16: counter width; HOLD_CYCLES and STALL_CYCLES SHALL each be below 2**CNT_W.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 SHALL have port BReset, input, 1 bit: system reset, asynchronous, active-high.
REQ-006 SHALL have port SoftRstReq, input, 1 bit: level request for a core soft reset.
REQ-007 SHALL have port SoftRstAck, output, 1 bit: one-cycle pulse when a soft request is accepted.
REQ-008 SHALL have port CoreBReset, output, 1 bit: reset driven to the Xtensa core BReset, active-high.
REQ-009 SHALL have port RunStall, output, 1 bit: core run-stall.
REQ-010 SHALL have port ResetDone, output, 1 bit: high only in state RUN.

Function
REQ-011 SHALL implement an FSM with states SYNC, HOLD, STALL, RUN and SOFT.
REQ-012 SHALL pass BReset release through a 2-flop synchronizer; SYNC SHALL exit to HOLD on the CLK edge at which the synchronized reset reads low.
REQ-013 HOLD SHALL count HOLD_CYCLES CLK edges; CoreBReset SHALL fall on the (2+HOLD_CYCLES)th rising CLK edge after BReset deasserts (edge 102 at the default).
REQ-014 On leaving HOLD, the FSM SHALL go to STALL if the macro is defined, otherwise to RUN.
REQ-015 STALL SHALL hold RunStall high for STALL_CYCLES edges, then go to RUN; RunStall SHALL be low in RUN.
REQ-016 SoftRstReq SHALL be accepted only in RUN and only on a 0-to-1 transition: a rising edge while in RUN, or a rising edge seen after a low-to-high change occurring outside RUN.
REQ-017 A request held high SHALL not retrigger; the next acceptance SHALL require SoftRstReq to go low and then high again.
REQ-018 On acceptance, the FSM SHALL enter SOFT: SoftRstAck high for exactly that cycle, CoreBReset high from the next edge, then HOLD with the synchronizer skipped.
REQ-019 A SoftRstReq rising edge in SYNC, HOLD or STALL SHALL be ignored, with no ack.
REQ-020 All outputs SHALL be registered.
REQ-021 Counters SHALL saturate and never wrap.
REQ-022 The counter SHALL be cleared on every state entry.

Reset
REQ-023 BReset high SHALL asynchronously force: state SYNC, counter 0, synchronizer flops 1, CoreBReset=1, RunStall=1, ResetDone=0, SoftRstAck=0.
REQ-024 BReset asserted mid-HOLD, mid-STALL or mid-SOFT SHALL abort the sequence, apply the REQ-023 values, and restart the full sequence from SYNC.

Configuration
REQ-025 Macro XTRST_RUNSTALL_EN, when defined, SHALL include the STALL state and the RunStall hold.
REQ-026 When XTRST_RUNSTALL_EN is undefined, RunStall SHALL equal CoreBReset, STALL SHALL be unreachable, and STALL_CYCLES SHALL be ignored.

Structure
REQ-027 A shared package xtensa_reset_pkg SHALL hold the state enum typedef and the default HOLD_CYCLES and STALL_CYCLES constants.
REQ-028 The block SHALL have one sub-module, xtrst_sync2: a 2-flop asynchronous-assert, synchronous-release synchronizer.

Verification
REQ-029 Power-on test: BReset high for 5 cycles, then low -> CoreBReset falls at edge 102; with the macro, RunStall falls at edge 118 and ResetDone rises at edge 118.
REQ-030 Soft reset test: in RUN, SoftRstReq pulse -> SoftRstAck high for 1 cycle, CoreBReset high for 1+100 cycles, and no synchronizer delay.
REQ-031 Held request test: SoftRstReq held high through the whole soft sequence -> exactly one ack; a second ack comes only after SoftRstReq goes low then high.
REQ-032 Mid-sequence reset test: BReset reasserted at HOLD count 50 -> all outputs return to reset values immediately; after release, CoreBReset falls 102 edges later.
REQ-033 Early request test: SoftRstReq rising edge during HOLD -> no ack, and the sequence timing is unchanged.
REQ-034 Zero-hold test: HOLD_CYCLES=0 -> CoreBReset falls at edge 3.

Source files
------------

// File: rtl/xtensa_reset_pkg.sv
// Shared types and defaults for the Xtensa core reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: sequencer state enum, default hold/stall lengths.
package xtensa_reset_pkg;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_STALL = 3'd2,
    ST_RUN   = 3'd3,
    ST_SOFT  = 3'd4
  } xtrst_state_t;

  localparam int unsigned DEF_HOLD_CYCLES  = 100;
  localparam int unsigned DEF_STALL_CYCLES = 16;

endpackage

// File: rtl/xtrst_sync2.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on CLK.
// Latency: release reaches rst_sync on the 2nd rising edge after arst falls.
// Backpressure: none.
// Ports: clk (clock), arst (async active-high reset in), rst_sync (synchronized reset out).
module xtrst_sync2 (
  input  logic clk,
  input  logic arst,
  output logic rst_sync
);

  logic meta;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta     <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      meta     <= 1'b0;
      rst_sync <= meta;
    end
  end

endmodule

// File: rtl/xtensa_reset_seq.sv
// Xtensa core reset sequencer: sync BReset release, hold CoreBReset, optional RunStall hold, soft reset.
// Latency: CoreBReset falls on edge 2+HOLD_CYCLES after BReset release; soft reset skips the synchronizer.
// Backpressure: none; SoftRstReq edges outside RUN are dropped, acceptance pulses SoftRstAck once.
// Ports: CLK, BReset (async active-high), SoftRstReq (level) -> SoftRstAck, CoreBReset, RunStall, ResetDone.
// Optional macro XTRST_RUNSTALL_EN adds the STALL state; without it RunStall mirrors CoreBReset.
module xtensa_reset_seq
  import xtensa_reset_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int unsigned CNT_W        = 16
) (
  input  logic CLK,
  input  logic BReset,
  input  logic SoftRstReq,
  output logic SoftRstAck,
  output logic CoreBReset,
  output logic RunStall,
  output logic ResetDone
);

  if (64'(HOLD_CYCLES) >= (64'd1 << CNT_W) || 64'(STALL_CYCLES) >= (64'd1 << CNT_W)) begin : g_param_check
    $error("xtensa_reset_seq: HOLD_CYCLES and STALL_CYCLES must be below 2**CNT_W");
  end

  localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;

  // HOLD leaves on the edge where cnt == tgt, i.e. tgt+1 edges after entry.
  // After power-on the SYNC exit edge is already one of the HOLD_CYCLES edges,
  // so that path uses a target one lower than the soft-reset path.
  localparam logic [CNT_W-1:0] HOLD_TGT_SOFT = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_TGT_PO   = CNT_W'(HOLD_EFF - 2);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
`ifdef XTRST_RUNSTALL_EN
  localparam logic [CNT_W-1:0] STALL_TGT     = CNT_W'(STALL_CYCLES - 1);
`endif

  xtrst_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tgt;
  logic             sync_rst;
  logic             req_q;
  logic             ack_q;
  logic             core_breset_q;
  logic             done_q;
  logic             hold_exit;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
`ifdef XTRST_RUNSTALL_EN
  logic             run_stall_q;
`endif

  xtrst_sync2 u_sync (
    .clk      (CLK),
    .arst     (BReset),
    .rst_sync (sync_rst)
  );

  // With a one-cycle hold the SYNC exit edge is the whole hold, so HOLD is skipped.
  always_comb begin
    hold_exit = 1'b0;
    if (state == ST_SYNC) begin
      hold_exit = !sync_rst && (HOLD_EFF == 1);
    end else if (state == ST_HOLD) begin
      hold_exit = (cnt == tgt);
    end
  end

  // req_q resets high so a request held across reset is not taken as a new edge.
  assign accept  = (state == ST_RUN) && SoftRstReq && !req_q;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      state         <= ST_SYNC;
      cnt           <= '0;
      tgt           <= '0;
      req_q         <= 1'b1;
      ack_q         <= 1'b0;
      core_breset_q <= 1'b1;
      done_q        <= 1'b0;
`ifdef XTRST_RUNSTALL_EN
      run_stall_q   <= 1'b1;
`endif
    end else begin
      req_q <= SoftRstReq;
      ack_q <= 1'b0;
      if (hold_exit) begin
        cnt           <= '0;
        core_breset_q <= 1'b0;
`ifdef XTRST_RUNSTALL_EN
        if (STALL_CYCLES == 0) begin
          state       <= ST_RUN;
          run_stall_q <= 1'b0;
          done_q      <= 1'b1;
        end else begin
          state       <= ST_STALL;
        end
`else
        state  <= ST_RUN;
        done_q <= 1'b1;
`endif
      end else begin
        case (state)
          ST_SYNC: begin
            if (!sync_rst) begin
              state <= ST_HOLD;
              cnt   <= '0;
              tgt   <= HOLD_TGT_PO;
            end
          end
          ST_HOLD: cnt <= cnt_inc;
`ifdef XTRST_RUNSTALL_EN
          ST_STALL: begin
            if (cnt == STALL_TGT) begin
              state       <= ST_RUN;
              cnt         <= '0;
              run_stall_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
`endif
          ST_RUN: begin
            if (accept) begin
              state         <= ST_SOFT;
              cnt           <= '0;
              ack_q         <= 1'b1;
              core_breset_q <= 1'b1;
              done_q        <= 1'b0;
`ifdef XTRST_RUNSTALL_EN
              run_stall_q   <= 1'b1;
`endif
            end
          end
          // Soft reset re-enters HOLD directly: the clock is already running.
          ST_SOFT: begin
            state <= ST_HOLD;
            cnt   <= '0;
            tgt   <= HOLD_TGT_SOFT;
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

  assign SoftRstAck = ack_q;
  assign CoreBReset = core_breset_q;
  assign ResetDone  = done_q;
`ifdef XTRST_RUNSTALL_EN
  assign RunStall   = run_stall_q;
`else
  assign RunStall   = core_breset_q;
`endif

endmodule
